fft_stream_feeder: RTL and testbench

- Producer side of the streaming FFT `next`/vector interface.
- Accepts real 16-bit audio samples one per cycle over a valid/ready handshake and collects them into ping-pong frame buffers of N samples.
- For each full frame, pulses `fft_next` for one cycle, then drives N/2 consecutive cycles of two complex samples (imaginary parts zero) on X0..X3 into the FFT core.
- Sits between the sample source (ADC/sample RAM) and the FFT top.

---
 rtl/fft_feed_pkg.sv | 16 +
 rtl/fft_feed_bank_ram.sv | 27 ++
 rtl/fft_stream_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_fft_stream_feeder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feed_pkg.sv
// Shared types and default sizing for the FFT stream feeder.
package fft_feed_pkg;

    localparam int FEED_N = 1024;
    localparam int FEED_W = 16;
    localparam int HALF   = FEED_N / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2
    } rd_state_t;

    typedef logic signed [FEED_W-1:0] sample_t;

endpackage

// File: rtl/fft_feed_bank_ram.sv
// Simple dual-port sub-bank RAM: one write port, one registered read port.
module fft_feed_bank_ram
    import fft_feed_pkg::*;
#(
    parameter int DEPTH = HALF,
    parameter int W     = FEED_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic signed [W-1:0] rdata
);

    logic signed [W-1:0] mem [DEPTH];

    // Write when enabled; read data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_stream_feeder.sv
// Collects real samples into ping-pong frame banks and streams each full
// frame to the FFT core as N/2 vectors of two complex samples.
module fft_stream_feeder
    import fft_feed_pkg::*;
#(
    parameter int N        = FEED_N,
    parameter int W        = FEED_W,
    parameter int IN_SHIFT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                fft_next,
    output logic signed [W-1:0] X0,
    output logic signed [W-1:0] X1,
    output logic signed [W-1:0] X2,
    output logic signed [W-1:0] X3,
    output logic [15:0]         frames_sent,
    output logic                busy
);

    localparam int HALF_N = N / 2;
    localparam int AW     = $clog2(HALF_N);
    localparam int IW     = $clog2(N);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [AW-1:0] T_ONE    = AW'(1);
    localparam logic [AW-1:0] T_LAST   = AW'(HALF_N - 1);

    // Pre-scale for FFT headroom; arithmetic shift keeps the sign.
    function automatic logic signed [W-1:0] pre_shift(input logic signed [W-1:0] s);
        return s >>> IN_SHIFT;
    endfunction

    logic                rdy_en;
    logic [1:0]          full;
    logic                wr_bank;
    logic                rd_bank;
    logic [IW-1:0]       wr_idx;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       t_cnt;
    logic [AW-1:0]       rd_addr;
    logic                accept;
    logic                frame_done;
    logic                stream_last;
    logic [1:0]          we_even;
    logic [1:0]          we_odd;
    logic signed [W-1:0] wr_data_p0;
    logic signed [W-1:0] rd_even_p1 [2];
    logic signed [W-1:0] rd_odd_p1  [2];
    rd_state_t           state;
    rd_state_t           state_nxt;

    assign sample_ready = rdy_en & ~full[wr_bank];
    assign accept       = sample_valid & sample_ready;
    assign frame_done   = accept && (wr_idx == IDX_LAST);
    assign stream_last  = (state == STREAM) && (t_cnt == T_LAST);
    assign wr_addr      = wr_idx[IW-1:1];
    assign wr_data_p0   = pre_shift(sample_in);
    assign busy         = (state == STREAM) | (|full);

    // Stage p0: route the accepted sample to the even or odd sub-bank of the write bank.
    always_comb begin
        we_even = '0;
        we_odd  = '0;
        if (accept) begin
            if (wr_idx[0]) begin
                we_odd[wr_bank] = 1'b1;
            end else begin
                we_even[wr_bank] = 1'b1;
            end
        end
    end

    // Stage p1: registered RAM read; ARM fetches address 0, STREAM prefetches t+1.
    always_comb begin
        rd_addr = '0;
        if (state == STREAM) begin
            rd_addr = t_cnt + T_ONE;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_feed_bank_ram #(.DEPTH(HALF_N), .W(W)) u_even (
            .clk   (clk),
            .we    (we_even[b]),
            .waddr (wr_addr),
            .wdata (wr_data_p0),
            .raddr (rd_addr),
            .rdata (rd_even_p1[b])
        );
        fft_feed_bank_ram #(.DEPTH(HALF_N), .W(W)) u_odd (
            .clk   (clk),
            .we    (we_odd[b]),
            .waddr (wr_addr),
            .wdata (wr_data_p0),
            .raddr (rd_addr),
            .rdata (rd_odd_p1[b])
        );
    end

    // Writer: hold off input until out of reset, advance index, flip bank at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en  <= 1'b0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                if (wr_idx == IDX_LAST) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IDX_ONE;
                end
            end
        end
    end

    // Bank flags: writer marks its bank full, reader frees its bank; they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= '0;
        end else begin
            if (frame_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (stream_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Vector counter, read bank and frame count advance with the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_cnt       <= '0;
            rd_bank     <= 1'b0;
            frames_sent <= '0;
        end else begin
            if (state == ARM) begin
                t_cnt <= '0;
            end else if (state == STREAM) begin
                t_cnt <= t_cnt + T_ONE;
            end
            if (stream_last) begin
                rd_bank     <= ~rd_bank;
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

    // Read FSM next state and frame-start pulse.
    always_comb begin
        state_nxt = state;
        fft_next  = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                fft_next  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (t_cnt == T_LAST) begin
                    state_nxt = full[~rd_bank] ? ARM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output vector: RAM data of the read bank while streaming, zero otherwise.
    always_comb begin
        X0 = '0;
        X1 = '0;
        X2 = '0;
        X3 = '0;
        if (state == STREAM) begin
            X0 = rd_even_p1[rd_bank];
            X2 = rd_odd_p1[rd_bank];
        end
    end

endmodule

// File: tb/tb_fft_stream_feeder.sv
// Directed bench for fft_stream_feeder: a 1024-point instance for framing,
// back-to-back, gap and reset scenarios, and a 4-point instance for the input shift.
module tb_fft_stream_feeder;

    localparam int TB_N    = 1024;
    localparam int TB_HALF = TB_N / 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic               fft_next;
    logic signed [15:0] x0, x1, x2, x3;
    logic [15:0]        frames_sent;
    logic               busy;

    logic signed [15:0] s_in = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic               s_next;
    logic signed [15:0] s_x0, s_x1, s_x2, s_x3;
    logic [15:0]        s_frames;
    logic               s_busy;

    int checks = 0;
    int errors = 0;

    logic        clr = 1'b0;
    int          cyc = 0;
    int          strm_cnt = 0;
    int          imag_bad = 0;
    int          idle_bad = 0;
    int          stall_cnt = 0;
    int          overlap_bad = 0;
    logic [31:0] out_q[$];
    logic [15:0] acc_q[$];
    int          acc_cyc_q[$];
    int          next_q[$];

    always #5 clk = ~clk;

    fft_stream_feeder #(.N(TB_N), .W(16), .IN_SHIFT(0)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fft_next     (fft_next),
        .X0           (x0),
        .X1           (x1),
        .X2           (x2),
        .X3           (x3),
        .frames_sent  (frames_sent),
        .busy         (busy)
    );

    fft_stream_feeder #(.N(4), .W(16), .IN_SHIFT(2)) u_dut_s (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (s_in),
        .sample_valid (s_valid),
        .sample_ready (s_ready),
        .fft_next     (s_next),
        .X0           (s_x0),
        .X1           (s_x1),
        .X2           (s_x2),
        .X3           (s_x3),
        .frames_sent  (s_frames),
        .busy         (s_busy)
    );

    // Record accepted samples, pulse cycles and streamed vectors at mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            out_q.delete();
            acc_q.delete();
            acc_cyc_q.delete();
            next_q.delete();
            strm_cnt    <= 0;
            imag_bad    <= 0;
            idle_bad    <= 0;
            stall_cnt   <= 0;
            overlap_bad <= 0;
        end else if (reset !== 1'b1) begin
            strm_cnt <= 0;
        end else begin
            if (sample_valid && sample_ready) begin
                acc_q.push_back(sample_in);
                acc_cyc_q.push_back(cyc + 1);
            end
            if (sample_valid && !sample_ready) stall_cnt <= stall_cnt + 1;
            if (strm_cnt > 0) begin
                out_q.push_back({x2, x0});
                if (x1 !== 16'sd0 || x3 !== 16'sd0) imag_bad <= imag_bad + 1;
            end else if (x0 !== 16'sd0 || x1 !== 16'sd0 || x2 !== 16'sd0 || x3 !== 16'sd0) begin
                idle_bad <= idle_bad + 1;
            end
            if (fft_next === 1'b1) begin
                next_q.push_back(cyc + 1);
                if (strm_cnt > 0) overlap_bad <= overlap_bad + 1;
                strm_cnt <= TB_HALF;
            end else if (strm_cnt > 0) begin
                strm_cnt <= strm_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        s_valid = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        clear_mon();
    endtask

    // Offer one sample and hold it until the feeder takes it (bounded wait).
    task automatic push(input logic [15:0] v);
        int guard = 0;
        sample_in = v;
        sample_valid = 1'b1;
        @(negedge clk);
        while (sample_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL push_timeout sample_ready stuck at %0b, required 1", sample_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Number of streamed vectors that differ from the accepted-sample order.
    function automatic int stream_mismatches();
        int m = 0;
        if (out_q.size() * 2 != acc_q.size()) m++;
        for (int k = 0; k < out_q.size() && 2 * k + 1 < acc_q.size(); k++) begin
            if (out_q[k] !== {acc_q[2 * k + 1], acc_q[2 * k]}) m++;
        end
        return m;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        sample_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%0b want=0", sample_ready);
        end
        checks++;
        if ({fft_next, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl got next=%0b busy=%0b want 0 0", fft_next, busy);
        end
        checks++;
        if (x0 !== 16'sd0 || x1 !== 16'sd0 || x2 !== 16'sd0 || x3 !== 16'sd0) begin
            errors++; $display("FAIL reset_x got=%h %h %h %h want all 0", x0, x1, x2, x3);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            errors++; $display("FAIL reset_frames got=%0d want=0", frames_sent);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got=%0b want=1", sample_ready);
        end
        clear_mon();
    endtask

    task automatic test_single_frame();
        int bad = 0;
        do_reset();
        for (int i = 0; i < TB_N; i++) push(16'(i));
        idle(530);
        checks++;
        if (next_q.size() != 1 || acc_cyc_q.size() != TB_N) begin
            errors++;
            $display("FAIL frame1_pulses got=%0d accepted=%0d want 1 and %0d", next_q.size(), acc_cyc_q.size(), TB_N);
        end else begin
            checks++;
            if (next_q[0] != acc_cyc_q[TB_N - 1] + 2) begin
                errors++; $display("FAIL frame1_latency got=%0d want=%0d", next_q[0], acc_cyc_q[TB_N - 1] + 2);
            end
        end
        checks++;
        if (out_q.size() != TB_HALF) begin
            errors++; $display("FAIL frame1_vectors got=%0d want=%0d", out_q.size(), TB_HALF);
        end
        for (int t = 0; t < out_q.size(); t++) begin
            if (out_q[t] !== {16'(2 * t + 1), 16'(2 * t)}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL frame1_data got %0d bad vectors want 0", bad);
        end
        checks++;
        if (imag_bad != 0 || idle_bad != 0) begin
            errors++; $display("FAIL frame1_zero_parts got imag=%0d idle=%0d want 0 0", imag_bad, idle_bad);
        end
        checks++;
        if (frames_sent !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL frame1_count got frames=%0d busy=%0b want 1 0", frames_sent, busy);
        end
    endtask

    task automatic test_back_to_back();
        int mm;
        do_reset();
        for (int i = 0; i < 3 * TB_N; i++) push(16'(i * 7 + 3));
        idle(530);
        checks++;
        if (next_q.size() != 3) begin
            errors++; $display("FAIL b2b_pulses got=%0d want=3", next_q.size());
        end else begin
            checks++;
            if (next_q[1] - next_q[0] != TB_N || next_q[2] - next_q[1] != TB_N) begin
                errors++;
                $display("FAIL b2b_spacing got=%0d,%0d want=%0d,%0d", next_q[1] - next_q[0], next_q[2] - next_q[1], TB_N, TB_N);
            end
        end
        checks++;
        if (stall_cnt != 0) begin
            errors++; $display("FAIL b2b_ready_drop got=%0d stalled cycles want=0", stall_cnt);
        end
        mm = stream_mismatches();
        checks++;
        if (mm != 0 || out_q.size() != 3 * TB_HALF) begin
            errors++; $display("FAIL b2b_data got %0d mismatches over %0d vectors want 0 over %0d", mm, out_q.size(), 3 * TB_HALF);
        end
        checks++;
        if (frames_sent !== 16'd3 || imag_bad != 0 || idle_bad != 0 || overlap_bad != 0) begin
            errors++;
            $display("FAIL b2b_misc got frames=%0d imag=%0d idle=%0d overlap=%0d want 3 0 0 0", frames_sent, imag_bad, idle_bad, overlap_bad);
        end
    endtask

    task automatic test_gaps();
        int mm;
        do_reset();
        for (int i = 0; i < 2 * TB_N; i++) begin
            while ($urandom_range(0, 1) == 0) idle(1);
            push(16'($urandom));
        end
        idle(530);
        checks++;
        if (next_q.size() != 2 || acc_cyc_q.size() != 2 * TB_N) begin
            errors++; $display("FAIL gaps_pulses got=%0d accepted=%0d want 2 and %0d", next_q.size(), acc_cyc_q.size(), 2 * TB_N);
        end else begin
            checks++;
            if (next_q[0] != acc_cyc_q[TB_N - 1] + 2 || next_q[1] != acc_cyc_q[2 * TB_N - 1] + 2) begin
                errors++;
                $display("FAIL gaps_timing got=%0d,%0d want=%0d,%0d", next_q[0], next_q[1], acc_cyc_q[TB_N - 1] + 2, acc_cyc_q[2 * TB_N - 1] + 2);
            end
        end
        mm = stream_mismatches();
        checks++;
        if (mm != 0) begin
            errors++; $display("FAIL gaps_data got %0d mismatches want 0", mm);
        end
        checks++;
        if (frames_sent !== 16'd2 || imag_bad != 0 || idle_bad != 0) begin
            errors++; $display("FAIL gaps_misc got frames=%0d imag=%0d idle=%0d want 2 0 0", frames_sent, imag_bad, idle_bad);
        end
    endtask

    task automatic test_shift();
        logic signed [15:0] vals [4];
        int g = 0;
        vals[0] = -16'sd8;
        vals[1] = 16'sd100;
        vals[2] = -16'sd1;
        vals[3] = 16'sd7;
        do_reset();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL shift_ready got=%0b want=1", s_ready);
        end
        for (int k = 0; k < 4; k++) begin
            s_in = vals[k];
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        while (s_next !== 1'b1 && g < 10) begin
            tick();
            g++;
        end
        checks++;
        if (g >= 10) begin
            errors++; $display("FAIL shift_next got no pulse want one within 10 cycles");
        end else begin
            tick();
            checks++;
            if (s_x0 !== 16'hFFFE || s_x2 !== 16'sd25 || s_x1 !== 16'sd0 || s_x3 !== 16'sd0) begin
                errors++; $display("FAIL shift_v0 got X0=%h X1=%h X2=%h X3=%h want fffe 0000 0019 0000", s_x0, s_x1, s_x2, s_x3);
            end
            tick();
            checks++;
            if (s_x0 !== 16'hFFFF || s_x2 !== 16'sd1) begin
                errors++; $display("FAIL shift_v1 got X0=%h X2=%h want ffff 0001", s_x0, s_x2);
            end
            tick();
            checks++;
            if (s_x0 !== 16'sd0 || s_x2 !== 16'sd0 || s_frames !== 16'd1) begin
                errors++; $display("FAIL shift_after got X0=%h X2=%h frames=%0d want 0 0 1", s_x0, s_x2, s_frames);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        int mm;
        do_reset();
        for (int i = 0; i < TB_N; i++) push(16'(i + 5));
        sample_valid = 1'b0;
        while (next_q.size() == 0 && g < 20) begin
            tick();
            g++;
        end
        checks++;
        if (next_q.size() == 0) begin
            errors++; $display("FAIL midrst_pulse got none want one");
        end else begin
            while (cyc < next_q[0] + 100 && g < 1000) begin
                tick();
                g++;
            end
            checks++;
            if (x0 !== 16'sd205 || x2 !== 16'sd206) begin
                errors++; $display("FAIL midrst_t100 got X0=%0d X2=%0d want 205 206", x0, x2);
            end
            #2;
            reset = 1'b0;
            #1;
            checks++;
            if (x0 !== 16'sd0 || x1 !== 16'sd0 || x2 !== 16'sd0 || x3 !== 16'sd0) begin
                errors++; $display("FAIL midrst_async_x got=%h %h %h %h want all 0", x0, x1, x2, x3);
            end
            checks++;
            if (fft_next !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0 || sample_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_async_ctrl got next=%0b busy=%0b frames=%0d ready=%0b want 0 0 0 0", fft_next, busy, frames_sent, sample_ready);
            end
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_mon();
        idle(600);
        checks++;
        if (next_q.size() != 0 || frames_sent !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_after got pulses=%0d frames=%0d busy=%0b want 0 0 0", next_q.size(), frames_sent, busy);
        end
        for (int i = 0; i < TB_N - 1; i++) push(16'(1000 + i));
        idle(5);
        checks++;
        if (next_q.size() != 0) begin
            errors++; $display("FAIL midrst_early_pulse got=%0d want=0", next_q.size());
        end
        push(16'(1000 + TB_N - 1));
        idle(530);
        mm = stream_mismatches();
        checks++;
        if (next_q.size() != 1 || mm != 0 || out_q.size() != TB_HALF) begin
            errors++;
            $display("FAIL midrst_fresh got pulses=%0d mismatches=%0d vectors=%0d want 1 0 %0d", next_q.size(), mm, out_q.size(), TB_HALF);
        end
        checks++;
        if (frames_sent !== 16'd1) begin
            errors++; $display("FAIL midrst_frames got=%0d want=1", frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_shift();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
